// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator.
// Provides the FSM state type, the default pattern/width and the counter
// width used for the repetition and gap counters.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int                       DEFAULT_WIDTH   = 3;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PATTERN = 3'b101;
    localparam int                       CNT_W           = 4;

endpackage

// File: rtl/pattern_generator_if.sv
// Control/stream bundle of the pattern generator.
//   start       burst request
//   repeat_cnt  repetitions per burst (0 behaves as 1)
//   gap_len     idle cycles between repetitions
//   data_out    serial bit stream
//   valid       data_out carries a pattern bit
//   busy        burst in progress
//   done        one-cycle burst completion pulse
// master: the side requesting bursts; slave: the generator.
interface pattern_generator_if;

    logic       start;
    logic [3:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       data_out;
    logic       valid;
    logic       busy;
    logic       done;

    modport master (
        output start, repeat_cnt, gap_len,
        input  data_out, valid, busy, done
    );

    modport slave (
        input  start, repeat_cnt, gap_len,
        output data_out, valid, busy, done
    );

endinterface

// File: rtl/pattern_gen_downcnt.sv
// Loadable down-counter with zero flag.
//   clk, rst_n  clock and asynchronous active-low reset (clears the count)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one; holds at zero instead of wrapping
//   count_o     current count
//   zero_o      count is zero
module pattern_gen_downcnt
    import pattern_gen_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pattern_generator.sv
// Serial pattern generator: on start, transmits PATTERN MSB first,
// repeated max(repeat_cnt,1) times with gap_len idle cycles between
// repetitions, then pulses done for one cycle.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pattern_generator_if.slave (start/repeat_cnt/gap_len in,
//          data_out/valid/busy/done out, all outputs registered)
module pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic                clk,
    input  logic                rst_n,
    pattern_generator_if.slave  bus
);

    localparam int BW = $clog2(WIDTH);

    // state_q and the counters describe the cycle currently on the outputs;
    // the output registers load the values for the following cycle.
    state_t     state_q, state_d;
    logic [3:0] gap_len_q, gap_len_d;
    logic       data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic          bit_load, bit_dec, bit_zero;
    logic [BW-1:0] bit_cnt, nxt_idx;
    logic          rep_load, rep_dec, rep_zero;
    logic [3:0]    rep_cnt, rep_load_val;
    logic          gap_load, gap_dec, gap_zero;
    logic [3:0]    gap_cnt, gap_load_val;

    // Repetition counter holds the repetitions still to come after the
    // current one, so a programmed 0 and 1 both load 0.
    assign rep_load_val = (bus.repeat_cnt == 4'd0) ? 4'd0 : bus.repeat_cnt - 4'd1;
    // Gap counter holds the gap cycles remaining after the current one.
    assign gap_load_val = gap_len_q - 4'd1;
    assign nxt_idx      = bit_cnt - BW'(1);

    always_comb begin
        state_d   = state_q;
        gap_len_d = gap_len_q;
        data_d    = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SEND;
                    gap_len_d = bus.gap_len;
                    bit_load  = 1'b1;
                    rep_load  = 1'b1;
                    data_d    = PATTERN[WIDTH-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SEND: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                    data_d  = PATTERN[nxt_idx];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_len_q == 4'd0) begin
                    rep_dec  = 1'b1;
                    bit_load = 1'b1;
                    data_d   = PATTERN[WIDTH-1];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = GAP;
                    rep_dec  = 1'b1;
                    gap_load = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d  = SEND;
                    bit_load = 1'b1;
                    data_d   = PATTERN[WIDTH-1];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_len_q <= 4'd0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_len_q <= gap_len_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    pattern_gen_downcnt #(.W(BW)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bit_load),
        .load_val_i (BW'(WIDTH - 1)),
        .dec_i      (bit_dec),
        .count_o    (bit_cnt),
        .zero_o     (bit_zero)
    );

    pattern_gen_downcnt #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (rep_load),
        .load_val_i (rep_load_val),
        .dec_i      (rep_dec),
        .count_o    (rep_cnt),
        .zero_o     (rep_zero)
    );

    pattern_gen_downcnt #(.W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .count_o    (gap_cnt),
        .zero_o     (gap_zero)
    );

    // Only the zero flags of the repetition and gap counters steer the FSM.
    logic unused_cnt;
    assign unused_cnt = ^{rep_cnt, gap_cnt};

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator (WIDTH=3, PATTERN=3'b101).
module tb_pattern_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pattern_generator_if bus();

    pattern_generator #(
        .WIDTH   (3),
        .PATTERN (3'b101)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {data_out, valid, busy, done}
    function automatic logic [3:0] obs();
        return {bus.data_out, bus.valid, bus.busy, bus.done};
    endfunction

    task automatic start_burst(input logic [3:0] r, input logic [3:0] g);
        bus.start      = 1'b1;
        bus.repeat_cnt = r;
        bus.gap_len    = g;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Expected masks: MSB is cycle 1 (first cycle after start is sampled).
    // st marks cycles during which start is held high (sampled at cycle end).
    // r2/g2 are driven on the inputs right after the initial start.
    task automatic run_seq(input string name,
                           input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] r2, input logic [3:0] g2,
                           input int n,
                           input logic [63:0] ed, input logic [63:0] ev,
                           input logic [63:0] eb, input logic [63:0] edn,
                           input logic [63:0] st);
        start_burst(r, g);
        bus.repeat_cnt = r2;
        bus.gap_len    = g2;
        for (int i = 0; i < n; i++) begin
            int k;
            k = n - 1 - i;
            check_eq($sformatf("%s c%0d", name, i + 1), {28'd0, obs()},
                     {28'd0, ed[k], ev[k], eb[k], edn[k]});
            bus.start = st[k];
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start      = 1'b0;
        bus.repeat_cnt = 4'd0;
        bus.gap_len    = 4'd0;
        #1 rst_n = 1'b0;
        #11;
        check_eq("reset_state", {28'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_seq("single", 4'd1, 4'd0, 4'd7, 4'd3, 5,
                64'b10100, 64'b11100, 64'b11100, 64'b00010, 64'd0);

        run_seq("b2b", 4'd3, 4'd0, 4'd0, 4'd0, 11,
                64'b10110110100, 64'b11111111100, 64'b11111111100,
                64'b00000000010, 64'd0);

        run_seq("gapped", 4'd2, 4'd2, 4'd2, 4'd2, 10,
                64'b1010010100, 64'b1110011100, 64'b1111111100,
                64'b0000000010, 64'd0);

        run_seq("rep0", 4'd0, 4'd5, 4'd0, 4'd5, 5,
                64'b10100, 64'b11100, 64'b11100, 64'b00010, 64'd0);

        run_seq("restart", 4'd0, 4'd0, 4'd2, 4'd1, 13,
                64'b1010101010100, 64'b1110111011100, 64'b1110111111100,
                64'b0001000000010, 64'b0101000000000);

        start_burst(4'd2, 4'd0);
        check_eq("abort c1", {28'd0, obs()}, {28'd0, 4'b1110});
        @(posedge clk);
        #2;
        check_eq("abort c2", {28'd0, obs()}, {28'd0, 4'b0110});
        rst_n = 1'b0;
        #1;
        check_eq("abort async", {28'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("abort idle%0d", i), {28'd0, obs()}, 32'd0);
        end

        run_seq("fresh", 4'd2, 4'd0, 4'd2, 4'd0, 8,
                64'b10110100, 64'b11111100, 64'b11111100, 64'b00000010, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_generator.md
PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 Parameter: WIDTH, 3, pattern length in bits (2..16).
REQ-002 Parameter: PATTERN, 3'b101, bit pattern to transmit, WIDTH bits wide.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request to begin a transmission burst; sampled on clk.
REQ-006 Port: repeat_cnt  input  4  number of pattern repetitions in the burst; 0 SHALL be treated as 1.
REQ-007 Port: gap_len  input  4  idle cycles inserted between repetitions; 0 means back-to-back.
REQ-008 Port: data_out  output  1  serial bit stream, registered.
REQ-009 Port: valid  output  1  high when data_out carries a pattern bit, registered.
REQ-010 Port: busy  output  1  high while a burst is in progress, registered.
REQ-011 Port: done  output  1  single-cycle pulse marking burst completion, registered.

Function
REQ-012 The FSM SHALL have states IDLE, SEND, GAP.
REQ-013 In IDLE: data_out=0, valid=0, busy=0; start=1 SHALL latch repeat_cnt and gap_len and transition to SEND.
REQ-014 Latency: the first pattern bit (PATTERN[WIDTH-1]) SHALL appear on data_out with valid=1 in the cycle after start is sampled.
REQ-015 Bits SHALL be sent MSB first, one per cycle, PATTERN[WIDTH-1] down to PATTERN[0], so a receiver shifting left reconstructs PATTERN.
REQ-016 After PATTERN[0]: if repetitions remain and latched gap_len=0, the SHALL be followed immediately by PATTERN[WIDTH-1] of the next repetition (no bubble).
REQ-017 After PATTERN[0]: if repetitions remain and latched gap_len>0, the FSM SHALL enter GAP for exactly gap_len cycles with data_out=0, valid=0, busy=1, then return to SEND.
REQ-018 After PATTERN[0] of the last repetition, the FSM SHALL return to IDLE; done=1 and busy=0 for exactly the following cycle.
REQ-019 busy SHALL be 1 from the cycle after start is sampled through the cycle carrying the final bit, including GAP cycles.
REQ-020 start while busy=1 SHALL be ignored; latched repeat_cnt/gap_len SHALL not change mid-burst.
REQ-021 start asserted in the done cycle SHALL be accepted (FSM is IDLE); next burst begins the following cycle.
REQ-022 Counters: bit index log2(WIDTH) bits down-counting, repetition counter 4 bits, gap counter 4 bits; no wrap beyond programmed values.
REQ-023 Total burst length in cycles SHALL be R*WIDTH + (R-1)*gap_len where R=max(repeat_cnt,1).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, data_out=0, valid=0, busy=0, done=0, and clear all counters and latched inputs.
REQ-025 Reset mid-burst SHALL abort the burst without a done pulse; first start after rst_n=1 SHALL begin a fresh burst.

Structure
REQ-026 Shared package pattern_gen_pkg SHALL hold the state enum typedef (IDLE, SEND, GAP) and the default pattern/width constants.
REQ-027 One sub-module, pattern_gen_downcnt (loadable down-counter with zero flag), SHALL be instantiated for bit, repetition and gap counting.

Verification
REQ-028 Reset: rst_n=0 at arbitrary time -> data_out, valid, busy, done all 0 within the same cycle, no clock required.
REQ-029 Single: start, repeat_cnt=1, gap_len=0 -> data_out 1,0,1 with valid=1 on cycles 1-3, done=1 on cycle 4, busy 1 on cycles 1-3.
REQ-030 Back-to-back: repeat_cnt=3, gap_len=0 -> 101101101 on cycles 1-9 continuous valid, done on cycle 10.
REQ-031 Gapped: repeat_cnt=2, gap_len=2 -> cycles 1-3 101 valid=1, cycles 4-5 data_out=0 valid=0 busy=1, cycles 6-8 101, done cycle 9.
REQ-032 Edge inputs: repeat_cnt=0 -> single repetition; start re-pulsed on cycle 2 -> ignored; start in done cycle -> new burst starts next cycle.
REQ-033 Abort: rst_n=0 during second bit of repeat_cnt=2 burst -> outputs 0, no done; after release, start -> full fresh burst 101101.
